inst_fetch_unit: RTL and testbench

//  Instruction fetch stage feeding the S-Machine CPU execute core. Reads the CPU's
//  8-bit PC, fetches the 16-bit word from program ROM over a req/ack handshake,
//  and presents it on inst with a one-cycle enable pulse. Also detects HALT,

---
 rtl/inst_fetch_unit_if.sv | 31 +++
 rtl/inst_fetch_unit.sv | 120 ++++++++++++
 tb/tb_inst_fetch_unit.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_unit_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : inst_fetch_unit_if
// Description : Program-ROM read bus between the fetch unit and the ROM.
//               The fetch unit is the master: it raises rom_req with a word
//               address and holds both until the ROM answers with rom_ack
//               and rom_data.
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_fetch_unit_if;
    logic        rom_req;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        rom_ack;

    modport master (
        output rom_req,
        output rom_addr,
        input  rom_data,
        input  rom_ack
    );

    modport slave (
        input  rom_req,
        input  rom_addr,
        output rom_data,
        output rom_ack
    );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : inst_fetch_unit
// Description : Instruction fetch stage for the S-Machine execute core.
//               Fetches the 16-bit word at the CPU's pc from program ROM
//               over a req/ack handshake, then presents it on inst with a
//               one-cycle enable strobe. Stops on a HALT opcode (0xF in the
//               top nibble) and on a ROM timeout, and counts issued
//               instructions with saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_unit #(
    parameter int TIMEOUT = 16,
    parameter int COUNT_W = 16
) (
    input  wire logic               clk,
    input  wire logic               reset_n,
    input  wire logic               run,
    input  wire logic [7:0]         pc,
    inst_fetch_unit_if.master       rom,
    output logic [15:0]             inst,
    output logic                    enable,
    output logic                    halted,
    output logic                    fault,
    output logic [COUNT_W-1:0]      instr_count
);

    // Wide enough to hold the value TIMEOUT itself.
    localparam int c_TCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_TCNT_W-1:0] c_TIMEOUT = c_TCNT_W'(TIMEOUT);
    localparam logic [3:0]          c_HALT_OP = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_ISSUE  = 3'd2,
        S_HALTED = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [c_TCNT_W-1:0]  r_tcount;
    logic [c_TCNT_W-1:0]  w_tcount_inc;
    logic                 w_ack_hit;
    logic                 w_is_halt;
    logic                 w_timeout;
    logic                 r_rom_req;
    logic [15:0]          r_inst;
    logic                 r_enable;
    logic                 r_halted;
    logic                 r_fault;
    logic [COUNT_W-1:0]   r_instr_count;

    // An ack only counts while a request is actually outstanding.
    assign w_ack_hit    = (r_state == S_FETCH) && rom.rom_ack;
    assign w_is_halt    = (rom.rom_data[15:12] == c_HALT_OP);
    assign w_tcount_inc = r_tcount + c_TCNT_W'(1);
    assign w_timeout    = (w_tcount_inc == c_TIMEOUT);

    // Next-state decode; an ack on the timeout edge takes priority over the fault.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (run) w_next_state = S_FETCH;
            S_FETCH: begin
                if (rom.rom_ack)    w_next_state = w_is_halt ? S_HALTED : S_ISSUE;
                else if (w_timeout) w_next_state = S_FAULT;
            end
            S_ISSUE:  w_next_state = run ? S_FETCH : S_IDLE;
            S_HALTED: w_next_state = S_HALTED;
            S_FAULT:  w_next_state = S_FAULT;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    // Registered outputs decoded from the upcoming state, plus timeout and issue counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rom_req     <= 1'b0;
            r_inst        <= 16'h0000;
            r_enable      <= 1'b0;
            r_halted      <= 1'b0;
            r_fault       <= 1'b0;
            r_instr_count <= '0;
            r_tcount      <= '0;
        end else begin
            r_rom_req <= (w_next_state == S_FETCH);
            r_enable  <= (w_next_state == S_ISSUE);
            r_halted  <= (w_next_state == S_HALTED);
            r_fault   <= (w_next_state == S_FAULT);

            if (w_ack_hit) r_inst <= rom.rom_data;

            if ((r_state == S_FETCH) && !rom.rom_ack) r_tcount <= w_tcount_inc;
            else                                      r_tcount <= '0;

            if (w_ack_hit && !w_is_halt && (r_instr_count != {COUNT_W{1'b1}}))
                r_instr_count <= r_instr_count + COUNT_W'(1);
        end
    end

    assign rom.rom_req  = r_rom_req;
    // Address follows pc combinationally so a branch taken on the issue edge is fetched directly.
    assign rom.rom_addr = (r_state == S_FETCH) ? pc : 8'h00;
    assign inst         = r_inst;
    assign enable       = r_enable;
    assign halted       = r_halted;
    assign fault        = r_fault;
    assign instr_count  = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch_unit
// Description : Self-checking bench for inst_fetch_unit. A small CPU model
//               advances pc on enable, a ROM model answers with a
//               programmable latency, and a transaction-level model predicts
//               every output each cycle; directed checks pin key values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_unit;
    localparam int TIMEOUT = 16;
    localparam int COUNT_W = 16;

    logic               clk     = 1'b0;
    logic               reset_n = 1'b0;
    logic               run     = 1'b0;
    logic [7:0]         pc      = 8'h00;
    logic [15:0]        inst;
    logic               enable;
    logic               halted;
    logic               fault;
    logic [COUNT_W-1:0] instr_count;

    inst_fetch_unit_if rom_bus ();

    inst_fetch_unit #(.TIMEOUT(TIMEOUT), .COUNT_W(COUNT_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .run         (run),
        .pc          (pc),
        .rom         (rom_bus),
        .inst        (inst),
        .enable      (enable),
        .halted      (halted),
        .fault       (fault),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cycle = 0;

    logic [15:0] mem [256];
    int          lat       = 1;     // ack on the lat-th cycle of a request; 0 = never
    bit          force_ack = 1'b0;  // unsolicited ack regardless of request
    int          req_seen  = 0;
    bit          pc_load   = 1'b0;
    logic [7:0]  pc_load_val = 8'h00;

    // CPU model: takes the instruction on enable; opcode 3 branches to the low byte.
    always @(posedge clk) begin
        if (pc_load)     pc <= pc_load_val;
        else if (enable) pc <= (inst[15:12] == 4'h3) ? inst[7:0] : pc + 8'd1;
    end

    // ROM model: answers on the falling edge so the ack is stable at the rising edge.
    always @(negedge clk) begin
        if (force_ack) begin
            rom_bus.rom_ack  = 1'b1;
            rom_bus.rom_data = 16'hDEAD;
        end else if (rom_bus.rom_req && lat != 0) begin
            req_seen++;
            if (req_seen == lat) begin
                rom_bus.rom_ack  = 1'b1;
                rom_bus.rom_data = mem[rom_bus.rom_addr];
            end else begin
                rom_bus.rom_ack  = 1'b0;
            end
        end else begin
            rom_bus.rom_ack = 1'b0;
            if (!rom_bus.rom_req) req_seen = 0;
        end
    end

    // Bus observer: length of the last request burst and addresses that were acked.
    int         req_run = 0;
    int         last_req_run = 0;
    logic [7:0] acked [$];
    always @(posedge clk) begin
        if (rom_bus.rom_req === 1'b1) begin
            req_run++;
            if (rom_bus.rom_ack === 1'b1) acked.push_back(rom_bus.rom_addr);
        end else if (req_run != 0) begin
            last_req_run = req_run;
            req_run      = 0;
        end
    end

    // Reference model: one fetch transaction at a time, described by what it is waiting for.
    bit          m_req, m_en, m_halt, m_fault;
    logic [15:0] m_inst  = 16'h0000;
    int          m_wait  = 0;
    int          m_count = 0;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_req = 0; m_en = 0; m_halt = 0; m_fault = 0;
            m_inst = 16'h0000; m_wait = 0; m_count = 0;
        end else if (m_halt || m_fault) begin
            m_req = 0; m_en = 0;
        end else if (m_req) begin
            if (rom_bus.rom_ack === 1'b1) begin
                m_inst = mem[pc];
                m_req  = 0;
                m_wait = 0;
                if (mem[pc][15:12] == 4'hF) m_halt = 1;
                else begin
                    m_en = 1;
                    if (m_count < (2**COUNT_W) - 1) m_count++;
                end
            end else begin
                m_wait++;
                if (m_wait >= TIMEOUT) begin
                    m_fault = 1;
                    m_req   = 0;
                end
            end
        end else if (m_en) begin
            m_en  = 0;
            m_req = run;
        end else begin
            m_req = run;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic compare_all();
        check("cmp_rom_req",  {31'd0, rom_bus.rom_req}, {31'd0, m_req});
        check("cmp_rom_addr", {24'd0, rom_bus.rom_addr}, m_req ? {24'd0, pc} : 32'd0);
        check("cmp_inst",     {16'd0, inst}, {16'd0, m_inst});
        check("cmp_enable",   {31'd0, enable}, {31'd0, m_en});
        check("cmp_halted",   {31'd0, halted}, {31'd0, m_halt});
        check("cmp_fault",    {31'd0, fault}, {31'd0, m_fault});
        check("cmp_count",    {16'd0, instr_count}, m_count);
    endtask

    // One clock: outputs compared 1 ns after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        compare_all();
        cycle++;
    endtask

    task automatic wait_en(input string name, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget && at < 0; i++) begin
            cyc();
            if (enable === 1'b1) at = cycle;
        end
        if (at < 0) begin
            tests++;
            fails++;
            $display("FAIL %s: no enable within %0d cycles, expected one", name, budget);
        end
    endtask

    int t1, t2, t3, t4, t5, t6, start, fault_at, en_seen;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
        mem[0] = 16'h2005;
        mem[1] = 16'h4000;
        mem[2] = 16'h3005;
        mem[4] = 16'hF000;
        mem[5] = 16'h1234;

        // Reset state
        repeat (3) cyc();
        check("rst_rom_req", {31'd0, rom_bus.rom_req}, 32'd0);
        check("rst_inst",    {16'd0, inst}, 32'd0);
        check("rst_count",   {16'd0, instr_count}, 32'd0);
        reset_n = 1'b1;

        // Ack while idle is ignored
        force_ack = 1'b1;
        repeat (2) cyc();
        force_ack = 1'b0;
        cyc();
        check("idle_ack_inst", {16'd0, inst}, 32'd0);

        // Zero-latency ROM: two instructions, two cycles apart
        lat = 1; acked.delete(); run = 1'b1;
        wait_en("t1_en1", 10, t1);
        check("t1_inst0", {16'd0, inst}, 32'h2005);
        wait_en("t1_en2", 10, t2);
        run = 1'b0;
        check("t1_inst1", {16'd0, inst}, 32'h4000);
        check("t1_spacing", t2 - t1, 32'd2);
        check("t1_count", {16'd0, instr_count}, 32'd2);
        check("t1_nacks", acked.size(), 32'd2);
        if (acked.size() == 2) begin
            check("t1_addr0", {24'd0, acked[0]}, 32'd0);
            check("t1_addr1", {24'd0, acked[1]}, 32'd1);
        end

        // Three-cycle ROM latency, then a branch from 2 to 5
        lat = 3; acked.delete(); run = 1'b1;
        wait_en("t2_en1", 20, t3);
        check("t3_inst_branch", {16'd0, inst}, 32'h3005);
        wait_en("t2_en2", 20, t4);
        run = 1'b0;
        check("t3_inst_target", {16'd0, inst}, 32'h1234);
        check("t2_spacing", t4 - t3, 32'd4);
        cyc();
        check("t2_req_cycles", last_req_run, 32'd3);
        check("t3_nacks", acked.size(), 32'd2);
        if (acked.size() == 2) begin
            check("t3_addr_branch", {24'd0, acked[0]}, 32'd2);
            check("t3_addr_target", {24'd0, acked[1]}, 32'd5);
        end
        check("t2_count", {16'd0, instr_count}, 32'd4);

        // HALT opcode at pc=4
        pc_load_val = 8'd4; pc_load = 1'b1;
        cyc();
        pc_load = 1'b0;
        lat = 1; acked.delete(); run = 1'b1; en_seen = 0;
        repeat (8) begin
            cyc();
            if (enable === 1'b1) en_seen++;
        end
        run = 1'b0;
        check("t4_halted", {31'd0, halted}, 32'd1);
        check("t4_no_enable", en_seen, 32'd0);
        check("t4_rom_req", {31'd0, rom_bus.rom_req}, 32'd0);
        check("t4_count", {16'd0, instr_count}, 32'd4);
        check("t4_inst", {16'd0, inst}, 32'hF000);
        check("t4_nacks", acked.size(), 32'd1);

        // ROM never answers: fault after TIMEOUT fetch cycles
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        pc_load_val = 8'd7; pc_load = 1'b1;
        cyc();
        pc_load = 1'b0;
        lat = 0; run = 1'b1; start = cycle; fault_at = -1;
        for (int i = 0; i < 40 && fault_at < 0; i++) begin
            cyc();
            if (fault === 1'b1) fault_at = cycle;
        end
        check("t5_fault_latency", fault_at - start, 32'd17);
        cyc();
        check("t5_req_cycles", last_req_run, 32'd16);
        check("t5_rom_req", {31'd0, rom_bus.rom_req}, 32'd0);
        force_ack = 1'b1;
        repeat (3) cyc();
        force_ack = 1'b0;
        run = 1'b0;
        check("t5_late_fault", {31'd0, fault}, 32'd1);
        check("t5_late_inst", {16'd0, inst}, 32'd0);
        check("t5_late_count", {16'd0, instr_count}, 32'd0);

        // Ack on the last allowed cycle wins over the timeout
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        lat = 16; run = 1'b1;
        wait_en("t5_ack16_en", 30, t5);
        run = 1'b0;
        check("t5_ack16_fault", {31'd0, fault}, 32'd0);
        check("t5_ack16_inst", {16'd0, inst}, 32'h1007);
        cyc();
        check("t5_ack16_req_cycles", last_req_run, 32'd16);

        // Asynchronous reset in the middle of a fetch
        lat = 0; run = 1'b1;
        repeat (4) cyc();
        check("t6_pre_req", {31'd0, rom_bus.rom_req}, 32'd1);
        check("t6_pre_addr", {24'd0, rom_bus.rom_addr}, 32'd8);
        #3;
        reset_n = 1'b0;
        #1;
        check("t6_rst_req",    {31'd0, rom_bus.rom_req}, 32'd0);
        check("t6_rst_addr",   {24'd0, rom_bus.rom_addr}, 32'd0);
        check("t6_rst_inst",   {16'd0, inst}, 32'd0);
        check("t6_rst_enable", {31'd0, enable}, 32'd0);
        check("t6_rst_halted", {31'd0, halted}, 32'd0);
        check("t6_rst_fault",  {31'd0, fault}, 32'd0);
        check("t6_rst_count",  {16'd0, instr_count}, 32'd0);
        cyc();
        reset_n = 1'b1;
        lat = 1; acked.delete();
        wait_en("t6_restart_en", 10, t6);
        run = 1'b0;
        check("t6_restart_inst", {16'd0, inst}, 32'h1008);
        check("t6_restart_count", {16'd0, instr_count}, 32'd1);
        if (acked.size() >= 1) check("t6_restart_addr", {24'd0, acked[0]}, 32'd8);
        else check("t6_restart_nacks", acked.size(), 32'd1);
        repeat (2) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
